// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Turns ASCII "W/R dev reg [dat] <CR|LF>" lines into one-cycle
//            command writes for the UART-to-IIC bridge command FIFO.
//            Define UART_CMD_TIMEOUT_EN to add an inter-byte timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic       CLK_I,
   input  logic       RSTN_I,
   input  logic [7:0] RX_DATA_I,
   input  logic       RX_VALID_I,
   output logic       WR_EN_O,
   output logic [6:0] WR_DEV_ADDR_O,
   output logic       WR_WRRD_O,
   output logic [7:0] WR_REG_ADDR_O,
   output logic [7:0] WR_REG_DATA_O,
   output logic       ERR_O
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_DEV_H = 4'd1,
      S_DEV_L = 4'd2,
      S_REG_H = 4'd3,
      S_REG_L = 4'd4,
      S_DAT_H = 4'd5,
      S_DAT_L = 4'd6,
      S_TERM  = 4'd7
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   state_t     w_digit_nxt;

   logic       r_op_rd;
   logic [7:0] r_dev;
   logic [7:0] r_reg;
   logic [7:0] r_dat;

   logic       w_is_space;
   logic       w_is_term;
   logic       w_is_wr;
   logic       w_is_rd;
   logic       w_is_hex;
   logic [3:0] w_nib;

   logic       w_start;
   logic       w_accept;
   logic       w_fire;
   logic       w_fail;
   logic       w_expire;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_cmd_parser: TIMEOUT_CYCLES must be at least 2");
   end

   // ------------------------------------------------------------------------
   // Byte classification
   // ------------------------------------------------------------------------
   always_comb begin
      w_is_space = (RX_DATA_I == 8'h20);
      w_is_term  = (RX_DATA_I == 8'h0D) || (RX_DATA_I == 8'h0A);
      w_is_wr    = (RX_DATA_I == 8'h57) || (RX_DATA_I == 8'h77);
      w_is_rd    = (RX_DATA_I == 8'h52) || (RX_DATA_I == 8'h72);
      w_is_hex   = ((RX_DATA_I >= 8'h30) && (RX_DATA_I <= 8'h39)) ||
                   ((RX_DATA_I >= 8'h41) && (RX_DATA_I <= 8'h46)) ||
                   ((RX_DATA_I >= 8'h61) && (RX_DATA_I <= 8'h66));
      // Bit 6 separates letters (both cases) from decimal digits.
      w_nib      = RX_DATA_I[6] ? (RX_DATA_I[3:0] + 4'd9) : RX_DATA_I[3:0];
   end

   // ------------------------------------------------------------------------
   // Inter-byte timeout
   // ------------------------------------------------------------------------
`ifdef UART_CMD_TIMEOUT_EN
   localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 32'd1);

   logic [31:0] r_idle_cnt;

   assign w_expire = (r_state != S_IDLE) && !RX_VALID_I &&
                     (r_idle_cnt == c_timeout_last);

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_idle_cnt <= 32'd0;
      end else if ((r_state == S_IDLE) || RX_VALID_I || w_expire) begin
         r_idle_cnt <= 32'd0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_digit_nxt = S_TERM;
      case (r_state)
         S_DEV_H: w_digit_nxt = S_DEV_L;
         S_DEV_L: w_digit_nxt = S_REG_H;
         S_REG_H: w_digit_nxt = S_REG_L;
         S_REG_L: w_digit_nxt = r_op_rd ? S_TERM : S_DAT_H;
         S_DAT_H: w_digit_nxt = S_DAT_L;
         default: w_digit_nxt = S_TERM;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_accept    = 1'b0;
      w_fire      = 1'b0;
      w_fail      = 1'b0;
      if (RX_VALID_I) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_wr || w_is_rd) begin
                  w_start     = 1'b1;
                  w_state_nxt = S_DEV_H;
               end
            end
            S_TERM: begin
               if (w_is_term) begin
                  if (r_dev[7]) w_fail = 1'b1;
                  else          w_fire = 1'b1;
               end else if (!w_is_space) begin
                  w_fail = 1'b1;
               end
            end
            default: begin
               if (w_is_hex) begin
                  w_accept    = 1'b1;
                  w_state_nxt = w_digit_nxt;
               end else if (!w_is_space) begin
                  w_fail = 1'b1;
               end
            end
         endcase
      end else if (w_expire) begin
         w_fail = 1'b1;
      end
      if (w_fail || w_fire) begin
         w_state_nxt = S_IDLE;
      end
   end

   // ------------------------------------------------------------------------
   // Shadow fields and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_op_rd       <= 1'b0;
         r_dev         <= 8'h00;
         r_reg         <= 8'h00;
         r_dat         <= 8'h00;
         WR_EN_O       <= 1'b0;
         ERR_O         <= 1'b0;
         WR_DEV_ADDR_O <= 7'h00;
         WR_WRRD_O     <= 1'b0;
         WR_REG_ADDR_O <= 8'h00;
         WR_REG_DATA_O <= 8'h00;
      end else begin
         WR_EN_O <= w_fire;
         ERR_O   <= w_fail;
         if (w_start) begin
            r_op_rd <= w_is_rd;
            r_dev   <= 8'h00;
            r_reg   <= 8'h00;
            r_dat   <= 8'h00;
         end
         if (w_accept) begin
            case (r_state)
               S_DEV_H: r_dev[7:4] <= w_nib;
               S_DEV_L: r_dev[3:0] <= w_nib;
               S_REG_H: r_reg[7:4] <= w_nib;
               S_REG_L: r_reg[3:0] <= w_nib;
               S_DAT_H: r_dat[7:4] <= w_nib;
               S_DAT_L: r_dat[3:0] <= w_nib;
               default: ;
            endcase
         end
         // Outputs only move on a completed command, never on partial parses.
         if (w_fire) begin
            WR_DEV_ADDR_O <= r_dev[6:0];
            WR_WRRD_O     <= r_op_rd;
            WR_REG_ADDR_O <= r_reg;
            WR_REG_DATA_O <= r_op_rd ? 8'h00 : r_dat;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Self-checking bench for uart_cmd_parser (table vectors plus
//            reset and inter-byte-timeout sequences).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_parser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       wr_en;
   logic [6:0] dev;
   logic       wrrd;
   logic [7:0] rega;
   logic [7:0] dat;
   logic       err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
      .CLK_I         (clk),
      .RSTN_I        (rst_n),
      .RX_DATA_I     (rx_data),
      .RX_VALID_I    (rx_valid),
      .WR_EN_O       (wr_en),
      .WR_DEV_ADDR_O (dev),
      .WR_WRRD_O     (wrrd),
      .WR_REG_ADDR_O (rega),
      .WR_REG_DATA_O (dat),
      .ERR_O         (err)
   );

   typedef struct {
      logic [127:0] seq;
      int           len;
      int           nwr;
      int           wr_at;
      int           nerr;
      int           err_at;
      logic [6:0]   dev;
      logic         wrrd;
      logic [7:0]   rega;
      logic [7:0]   dat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte k sits at the left of the right-aligned string literal; sample #1
   // after each edge so index k reports what byte k caused.
   task automatic send_seq(input logic [127:0] seq, input int len,
                           output int nwr, output int wr_at,
                           output int nerr, output int err_at);
      nwr = 0; wr_at = -1; nerr = 0; err_at = -1;
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         if (k < len) begin
            rx_data  = seq[8*(len-1-k) +: 8];
            rx_valid = 1'b1;
         end else begin
            rx_data  = 8'h00;
            rx_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (wr_en) begin nwr++; wr_at = k; end
         if (err)   begin nerr++; err_at = k; end
         check("wr_err_exclusive", {31'd0, wr_en & err}, 32'd0);
      end
   endtask

   task automatic idle_cycles(input int n, output int nerr, output int first);
      nerr = 0; first = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         @(posedge clk);
         #1;
         if (err) begin
            nerr++;
            if (first < 0) first = i;
         end
      end
   endtask

   task automatic check_outs(input string tag, input logic [6:0] e_dev, input logic e_wrrd,
                             input logic [7:0] e_reg, input logic [7:0] e_dat);
      check({tag, ".dev"},  {25'd0, dev},  {25'd0, e_dev});
      check({tag, ".wrrd"}, {31'd0, wrrd}, {31'd0, e_wrrd});
      check({tag, ".reg"},  {24'd0, rega}, {24'd0, e_reg});
      check({tag, ".dat"},  {24'd0, dat},  {24'd0, e_dat});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nwr, wr_at, nerr, err_at, first;

      vecs[0]  = '{"W50A3 5C\015",        9, 1,  8, 0, -1, 7'h50, 1'b0, 8'hA3, 8'h5C};
      vecs[1]  = '{"r1a0f\012",           6, 1,  5, 0, -1, 7'h1A, 1'b1, 8'h0F, 8'h00};
      vecs[2]  = '{"W5G",                 3, 0, -1, 1,  2, 7'h1A, 1'b1, 8'h0F, 8'h00};
      vecs[3]  = '{"W2001FF\015",         8, 1,  7, 0, -1, 7'h20, 1'b0, 8'h01, 8'hFF};
      vecs[4]  = '{"W8000 11\015",        9, 0, -1, 1,  8, 7'h20, 1'b0, 8'h01, 8'hFF};
      vecs[5]  = '{"R12\015",             4, 0, -1, 1,  3, 7'h20, 1'b0, 8'h01, 8'hFF};
      vecs[6]  = '{"\015 \012X",          4, 0, -1, 0, -1, 7'h20, 1'b0, 8'h01, 8'hFF};
      vecs[7]  = '{"w7Fff00\015",         8, 1,  7, 0, -1, 7'h7F, 1'b0, 8'hFF, 8'h00};
      vecs[8]  = '{"R0102\015W0304 05\012", 15, 2, 14, 0, -1, 7'h03, 1'b0, 8'h04, 8'h05};
      vecs[9]  = '{"W1 2\015",            5, 0, -1, 1,  4, 7'h03, 1'b0, 8'h04, 8'h05};
      vecs[10] = '{"R3e Cd  \015",        9, 1,  8, 0, -1, 7'h3E, 1'b1, 8'hCD, 8'h00};
      vecs[11] = '{"W1:",                 3, 0, -1, 1,  2, 7'h3E, 1'b1, 8'hCD, 8'h00};
      vecs[12] = '{"W1@",                 3, 0, -1, 1,  2, 7'h3E, 1'b1, 8'hCD, 8'h00};
      vecs[13] = '{"R1234Z",              6, 0, -1, 1,  5, 7'h3E, 1'b1, 8'hCD, 8'h00};
      vecs[14] = '{"12W345678\012",      10, 1,  9, 0, -1, 7'h34, 1'b0, 8'h56, 8'h78};
      vecs[15] = '{"W12345678\015",      10, 0, -1, 1,  7, 7'h34, 1'b0, 8'h56, 8'h78};

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(posedge clk);
      #1;
      check("reset.wr_en", {31'd0, wr_en}, 32'd0);
      check("reset.err",   {31'd0, err},   32'd0);
      check_outs("reset", 7'h00, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 16; v++) begin
         send_seq(vecs[v].seq, vecs[v].len, nwr, wr_at, nerr, err_at);
         check($sformatf("v%0d.nwr", v),    nwr,    vecs[v].nwr);
         check($sformatf("v%0d.wr_at", v),  wr_at,  vecs[v].wr_at);
         check($sformatf("v%0d.nerr", v),   nerr,   vecs[v].nerr);
         check($sformatf("v%0d.err_at", v), err_at, vecs[v].err_at);
         check_outs($sformatf("v%0d", v), vecs[v].dev, vecs[v].wrrd, vecs[v].rega, vecs[v].dat);
      end

      // Asynchronous reset in the middle of a command.
      send_seq("W12A", 4, nwr, wr_at, nerr, err_at);
      check("rst_mid.nwr",  nwr,  0);
      check("rst_mid.nerr", nerr, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async.wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_async.err",   {31'd0, err},   32'd0);
      check_outs("rst_async", 7'h00, 1'b0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_seq("\015", 1, nwr, wr_at, nerr, err_at);
      check("rst_after.nwr",  nwr,  0);
      check("rst_after.nerr", nerr, 0);
      check_outs("rst_after", 7'h00, 1'b0, 8'h00, 8'h00);

`ifdef UART_CMD_TIMEOUT_EN
      // Tail sample of send_seq is idle cycle 1, so expiry lands on idle loop index 99.
      send_seq("W12", 3, nwr, wr_at, nerr, err_at);
      check("to.pre_nerr", nerr, 0);
      idle_cycles(120, nerr, first);
      check("to.nerr",  nerr,  1);
      check("to.first", first, 99);
      send_seq("R3344\015", 6, nwr, wr_at, nerr, err_at);
      check("to.post_nwr",   nwr,   1);
      check("to.post_wr_at", wr_at, 5);
      check("to.post_nerr",  nerr,  0);
      check_outs("to.post", 7'h33, 1'b1, 8'h44, 8'h00);
`else
      // Without the timeout the parser waits indefinitely mid-command.
      send_seq("W12", 3, nwr, wr_at, nerr, err_at);
      check("wait.pre_nerr", nerr, 0);
      idle_cycles(150, nerr, first);
      check("wait.nerr", nerr, 0);
      send_seq("3456\015", 5, nwr, wr_at, nerr, err_at);
      check("wait.nwr",   nwr,   1);
      check("wait.wr_at", wr_at, 4);
      check("wait.nerr2", nerr,  0);
      check_outs("wait", 7'h12, 1'b0, 8'h34, 8'h56);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in CLK_I cycles (10 ms at 100 MHz); legal range 2..2^32-1.
REQ-002 CLK_I  input  1  single system clock; all logic on its rising edge.
REQ-003 RSTN_I  input  1  reset, asynchronous, active-low.
REQ-004 RX_DATA_I  input  8  received UART byte (ASCII); sampled only when RX_VALID_I=1.
REQ-005 RX_VALID_I  input  1  one-cycle strobe per received byte.
REQ-006 WR_EN_O  output  1  one-cycle command strobe to the downstream UART-to-IIC bridge command FIFO write port.
REQ-007 WR_DEV_ADDR_O  output  7  IIC 7-bit device address.
REQ-008 WR_WRRD_O  output  1  0 = write, 1 = read.
REQ-009 WR_REG_ADDR_O  output  8  register address.
REQ-010 WR_REG_DATA_O  output  8  write data; 0x00 for read commands.
REQ-011 ERR_O  output  1  one-cycle strobe on any discarded command.

Function
REQ-012 Grammar: cmd letter, DEV(2 hex), REG(2 hex), [DAT(2 hex) for write only], terminator; cmd letter 'W'/'w' = write, 'R'/'r' = read.
REQ-013 Hex digits: 0x30-0x39, 0x41-0x46, 0x61-0x66; high nibble first.
REQ-014 Terminator: CR (0x0D) or LF (0x0A).
REQ-015 Space (0x20) after the cmd letter and before the terminator: ignored, no state change.
REQ-016 States: IDLE, DEV_H, DEV_L, REG_H, REG_L, DAT_H, DAT_L, TERM; advance one state per accepted byte; REG_L->TERM on read, REG_L->DAT_H on write; DAT_L->TERM.
REQ-017 IDLE: 'W'/'w'/'R'/'r' -> DEV_H and latch the op; CR, LF, space and all other bytes ignored silently, no ERR_O.
REQ-018 Non-IDLE: a byte not legal for the current state (non-hex in a digit state, non-terminator in TERM, terminator before TERM) -> ERR_O=1 for one cycle, return to IDLE, no WR_EN_O.
REQ-019 Terminator in TERM with DEV > 0x7F -> ERR_O pulse, no WR_EN_O, return to IDLE.
REQ-020 Valid terminator in TERM -> next cycle: WR_EN_O=1 for exactly one cycle, with all four command outputs updated in that same cycle; return to IDLE.
REQ-021 Latency: terminator strobe at cycle N -> WR_EN_O high at cycle N+1.
REQ-022 Command outputs hold their values until the next WR_EN_O; partial parses never alter them (shadow registers).
REQ-023 WR_EN_O and ERR_O are never high in the same cycle.
REQ-024 Back-to-back bytes on consecutive cycles are accepted; a cmd letter on the cycle after a terminator starts a new command.
REQ-025 The downstream FIFO has no backpressure; full-FIFO handling is outside this block.

Reset
REQ-026 RSTN_I low: state=IDLE; WR_EN_O, ERR_O, WR_DEV_ADDR_O, WR_WRRD_O, WR_REG_ADDR_O, WR_REG_DATA_O, shadow registers and timeout counter all 0; takes effect asynchronously.
REQ-027 Reset mid-command discards the partial command without ERR_O; release is synchronous to CLK_I.

Configuration
REQ-028 Macro UART_CMD_TIMEOUT_EN defined: in any non-IDLE state, a counter counts cycles without RX_VALID_I; at TIMEOUT_CYCLES -> ERR_O pulse, return to IDLE, counter cleared; RX_VALID_I clears the counter, and a byte arriving in the expiry cycle takes priority over the timeout.
REQ-029 UART_CMD_TIMEOUT_EN undefined: no counter logic; parser waits indefinitely in any state.

Verification
REQ-030 Bytes "W50A3 5C\r" -> one WR_EN_O, DEV=0x50, WRRD=0, REG=0xA3, DAT=0x5C, 1 cycle after '\r'.
REQ-031 Bytes "r1a0f\n" -> one WR_EN_O, DEV=0x1A, WRRD=1, REG=0x0F, DAT=0x00.
REQ-032 "W5G" -> ERR_O on 'G'; then "W2001FF\r" -> WR_EN_O with DEV=0x20, REG=0x01, DAT=0xFF; prior outputs unchanged between the two.
REQ-033 "W8000 11\r" -> ERR_O at terminator, no WR_EN_O; "R12\r" -> ERR_O at '\r'.
REQ-034 UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: "W12" then idle 100 cycles -> ERR_O once; then "R3344\r" -> WR_EN_O DEV=0x33, REG=0x44.
REQ-035 RSTN_I low after "W12A" -> all outputs 0; after release, "\r" produces neither WR_EN_O nor ERR_O.
